object_marker_overlay: RTL and testbench

- Downstream consumer of the coordinate-to-pixel stage. Holds a table of object pixel positions (pixel_x 11b, pixel_y 10b) and paints a square marker for each one onto the 1024x768 XVGA pixel stream.
- Double-buffered: software/FSM writes go to a shadow table, which is copied to the active table at each frame boundary (vsync falling edge). This keeps markers tear-free.
- Sits between the XVGA timing/background generator and the final video output register.

---
 rtl/object_marker_overlay.sv | 148 ++++++++++++++
 tb/tb_object_marker_overlay.sv | 272 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/object_marker_overlay.sv
// rtl/object_marker_overlay.sv - double-buffered square marker overlay on the 1024x768 pixel stream
// Optional MARKER_CROSSHAIR_EN draws each marker as a plus-sign instead of a filled square.
module object_marker_overlay #(
   parameter int          NUM_OBJ    = 8,
   parameter int          IDX_W      = 3,
   parameter int          MARK_HALF  = 4,
   parameter logic [23:0] MARK_COLOR = 24'hFF0000
) (
   input  logic             clk,
   input  logic             reset_n,
   input  logic             obj_we,
   input  logic [IDX_W-1:0] obj_idx,
   input  logic [10:0]      obj_px,
   input  logic [9:0]       obj_py,
   input  logic             obj_valid,
   input  logic             frame_clear,
   input  logic [10:0]      hcount,
   input  logic [9:0]       vcount,
   input  logic             hsync,
   input  logic             vsync,
   input  logic             blank,
   input  logic [23:0]      in_pixel,
   output logic [23:0]      out_pixel,
   output logic             out_hsync,
   output logic             out_vsync,
   output logic             out_blank,
   output logic [IDX_W:0]   obj_count
);

   localparam logic signed [11:0] HALF = 12'(MARK_HALF);

   logic [NUM_OBJ-1:0] sh_valid_q, sh_valid_d, act_valid_q;
   logic [10:0]        sh_px_q [NUM_OBJ];
   logic [10:0]        sh_px_d [NUM_OBJ];
   logic [9:0]         sh_py_q [NUM_OBJ];
   logic [9:0]         sh_py_d [NUM_OBJ];
   logic [10:0]        act_px_q [NUM_OBJ];
   logic [9:0]         act_py_q [NUM_OBJ];
   logic               vsync_d_q;
   logic               swap;

   logic [NUM_OBJ-1:0] hit_d, s1_hit_q;
   logic [23:0]        s1_pixel_q;
   logic               s1_hsync_q, s1_vsync_q, s1_blank_q;
   logic [23:0]        out_pixel_q, out_pixel_d;
   logic               out_hsync_q, out_vsync_q, out_blank_q;
   logic [IDX_W:0]     obj_count_q, obj_count_d;

   function automatic logic entry_hit(input logic valid, input logic [10:0] px, input logic [9:0] py,
                                      input logic [10:0] hc, input logic [9:0] vc);
      logic signed [11:0] dx;
      logic signed [11:0] dy;
      logic               in_box;
      dx = $signed({1'b0, hc}) - $signed({1'b0, px});
      dy = $signed({2'b00, vc}) - $signed({2'b00, py});
      // Off-screen coordinates (e.g. wrapped 767-y from upstream) must never draw.
      in_box = valid && (px <= 11'd1023) && (py <= 10'd767) &&
               (dx >= -HALF) && (dx <= HALF) && (dy >= -HALF) && (dy <= HALF);
`ifdef MARKER_CROSSHAIR_EN
      return in_box && ((dx == 12'sd0) || (dy == 12'sd0));
`else
      return in_box;
`endif
   endfunction

   assign swap = vsync_d_q & ~vsync;

   always_comb begin
      sh_valid_d = sh_valid_q;
      sh_px_d    = sh_px_q;
      sh_py_d    = sh_py_q;
      if (frame_clear) begin
         sh_valid_d = '0;
      end
      // Clear first, so a write in the same cycle survives it.
      for (int i = 0; i < NUM_OBJ; i++) begin
         if (obj_we && (obj_idx == IDX_W'(i))) begin
            sh_valid_d[i] = obj_valid;
            sh_px_d[i]    = obj_px;
            sh_py_d[i]    = obj_py;
         end
      end
   end

   always_comb begin
      hit_d       = '0;
      obj_count_d = '0;
      for (int i = 0; i < NUM_OBJ; i++) begin
         hit_d[i]    = entry_hit(act_valid_q[i], act_px_q[i], act_py_q[i], hcount, vcount);
         obj_count_d = obj_count_d + (IDX_W+1)'(act_valid_q[i]);
      end
   end

   always_comb begin
      out_pixel_d = s1_blank_q ? 24'h000000 : ((|s1_hit_q) ? MARK_COLOR : s1_pixel_q);
   end

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         sh_valid_q  <= '0;
         act_valid_q <= '0;
         vsync_d_q   <= 1'b1;
         s1_hit_q    <= '0;
         s1_pixel_q  <= '0;
         s1_hsync_q  <= 1'b1;
         s1_vsync_q  <= 1'b1;
         s1_blank_q  <= 1'b1;
         out_pixel_q <= '0;
         out_hsync_q <= 1'b1;
         out_vsync_q <= 1'b1;
         out_blank_q <= 1'b1;
         obj_count_q <= '0;
      end else begin
         sh_valid_q  <= sh_valid_d;
         if (swap) begin
            act_valid_q <= sh_valid_q;
         end
         vsync_d_q   <= vsync;
         s1_hit_q    <= hit_d;
         s1_pixel_q  <= in_pixel;
         s1_hsync_q  <= hsync;
         s1_vsync_q  <= vsync;
         s1_blank_q  <= blank;
         out_pixel_q <= out_pixel_d;
         out_hsync_q <= s1_hsync_q;
         out_vsync_q <= s1_vsync_q;
         out_blank_q <= s1_blank_q;
         obj_count_q <= obj_count_d;
      end
   end

   // Coordinates carry no reset; the valid bits alone decide whether an entry draws.
   always_ff @(posedge clk) begin
      sh_px_q <= sh_px_d;
      sh_py_q <= sh_py_d;
      if (swap) begin
         act_px_q <= sh_px_q;
         act_py_q <= sh_py_q;
      end
   end

   assign out_pixel = out_pixel_q;
   assign out_hsync = out_hsync_q;
   assign out_vsync = out_vsync_q;
   assign out_blank = out_blank_q;
   assign obj_count = obj_count_q;

endmodule

// File: tb/tb_object_marker_overlay.sv
// tb/tb_object_marker_overlay.sv - randomized bench with an arithmetic reference model for object_marker_overlay
module tb_object_marker_overlay;

   localparam int          NUM_OBJ    = 6;
   localparam int          IDX_W      = 3;
   localparam int          MARK_HALF  = 4;
   localparam logic [23:0] MARK_COLOR = 24'hFF0000;

   logic             clk = 1'b0;
   logic             reset_n;
   logic             obj_we;
   logic [IDX_W-1:0] obj_idx;
   logic [10:0]      obj_px;
   logic [9:0]       obj_py;
   logic             obj_valid;
   logic             frame_clear;
   logic [10:0]      hcount;
   logic [9:0]       vcount;
   logic             hsync;
   logic             vsync;
   logic             blank;
   logic [23:0]      in_pixel;
   logic [23:0]      out_pixel;
   logic             out_hsync;
   logic             out_vsync;
   logic             out_blank;
   logic [IDX_W:0]   obj_count;

   always #5 clk = ~clk;

   object_marker_overlay #(
      .NUM_OBJ(NUM_OBJ), .IDX_W(IDX_W), .MARK_HALF(MARK_HALF), .MARK_COLOR(MARK_COLOR)
   ) dut (
      .clk(clk), .reset_n(reset_n), .obj_we(obj_we), .obj_idx(obj_idx), .obj_px(obj_px),
      .obj_py(obj_py), .obj_valid(obj_valid), .frame_clear(frame_clear), .hcount(hcount),
      .vcount(vcount), .hsync(hsync), .vsync(vsync), .blank(blank), .in_pixel(in_pixel),
      .out_pixel(out_pixel), .out_hsync(out_hsync), .out_vsync(out_vsync),
      .out_blank(out_blank), .obj_count(obj_count)
   );

   int checks = 0;
   int errors = 0;

   // Reference model: shadow/active tables as plain integers.
   int sh_v [NUM_OBJ];
   int sh_x [NUM_OBJ];
   int sh_y [NUM_OBJ];
   int ac_v [NUM_OBJ];
   int ac_x [NUM_OBJ];
   int ac_y [NUM_OBJ];
   int vs_prev = 1;
   logic [23:0] s1_pix_e = '0;
   logic        s1_hs_e = 1'b1, s1_vs_e = 1'b1, s1_bl_e = 1'b1;
   bit          rnd_mode = 1'b0;
   bit          force_blank = 1'b0;

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
      end
   endtask

   function automatic bit model_hit(input int h, input int v);
      for (int i = 0; i < NUM_OBJ; i++) begin
         if (ac_v[i] != 0 && ac_x[i] <= 1023 && ac_y[i] <= 767) begin
            int dx = h - ac_x[i];
            int dy = v - ac_y[i];
            int adx = (dx < 0) ? -dx : dx;
            int ady = (dy < 0) ? -dy : dy;
`ifdef MARKER_CROSSHAIR_EN
            if (adx <= MARK_HALF && ady <= MARK_HALF && (dx == 0 || dy == 0)) return 1'b1;
`else
            if (adx <= MARK_HALF && ady <= MARK_HALF) return 1'b1;
`endif
         end
      end
      return 1'b0;
   endfunction

   task automatic tick();
      logic [23:0] op_e;
      logic        oh_e, ov_e, ob_e;
      int          cnt_e;
      if (!reset_n) begin
         op_e = '0; oh_e = 1'b1; ov_e = 1'b1; ob_e = 1'b1; cnt_e = 0;
         s1_pix_e = '0; s1_hs_e = 1'b1; s1_vs_e = 1'b1; s1_bl_e = 1'b1;
         for (int i = 0; i < NUM_OBJ; i++) begin
            sh_v[i] = 0;
            ac_v[i] = 0;
         end
         vs_prev = 1;
      end else begin
         op_e = s1_pix_e; oh_e = s1_hs_e; ov_e = s1_vs_e; ob_e = s1_bl_e;
         cnt_e = 0;
         for (int i = 0; i < NUM_OBJ; i++) cnt_e += ac_v[i];
         s1_pix_e = blank ? 24'h0 : (model_hit(int'(hcount), int'(vcount)) ? MARK_COLOR : in_pixel);
         s1_hs_e = hsync; s1_vs_e = vsync; s1_bl_e = blank;
         if (vs_prev == 1 && vsync == 1'b0) begin
            for (int i = 0; i < NUM_OBJ; i++) begin
               ac_v[i] = sh_v[i]; ac_x[i] = sh_x[i]; ac_y[i] = sh_y[i];
            end
         end
         if (frame_clear) begin
            for (int i = 0; i < NUM_OBJ; i++) sh_v[i] = 0;
         end
         if (obj_we && int'(obj_idx) < NUM_OBJ) begin
            sh_v[obj_idx] = int'(obj_valid);
            sh_x[obj_idx] = int'(obj_px);
            sh_y[obj_idx] = int'(obj_py);
         end
         vs_prev = int'(vsync);
      end
      @(posedge clk);
      #1;
      check_eq("out_pixel", out_pixel, op_e);
      check_eq("out_hsync", out_hsync, oh_e);
      check_eq("out_vsync", out_vsync, ov_e);
      check_eq("out_blank", out_blank, ob_e);
      check_eq("obj_count", obj_count, cnt_e);
      obj_we = 1'b0;
      frame_clear = 1'b0;
   endtask

   task automatic set_write(input int idx, input int px, input int py, input bit v);
      obj_we = 1'b1; obj_idx = IDX_W'(idx); obj_px = 11'(px); obj_py = 10'(py); obj_valid = v;
   endtask

   task automatic wr(input int idx, input int px, input int py, input bit v);
      set_write(idx, px, py, v);
      tick();
   endtask

   task automatic vpulse_wr(input bit do_wr, input int idx, input int px, input int py);
      vsync = 1'b0;
      if (do_wr) set_write(idx, px, py, 1'b1);
      tick();
      tick();
      vsync = 1'b1;
      tick();
   endtask

   task automatic pix_at(input int h, input int v);
      hcount = 11'(h);
      vcount = 10'(v);
      hsync  = rnd_mode ? 1'($urandom_range(0, 1)) : ~hsync;
      blank  = force_blank | (rnd_mode && $urandom_range(0, 7) == 0);
      if (rnd_mode) in_pixel = 24'($urandom);
      tick();
   endtask

   task automatic scan_win(input int x, input int y);
      int h0 = (x - MARK_HALF - 1 < 0) ? 0 : x - MARK_HALF - 1;
      int h1 = (x + MARK_HALF + 1 > 2047) ? 2047 : x + MARK_HALF + 1;
      int v0 = (y - MARK_HALF - 1 < 0) ? 0 : y - MARK_HALF - 1;
      int v1 = (y + MARK_HALF + 1 > 1023) ? 1023 : y + MARK_HALF + 1;
      for (int v = v0; v <= v1; v++)
         for (int h = h0; h <= h1; h++)
            pix_at(h, v);
   endtask

   function automatic int rnd_px();
      return ($urandom_range(0, 9) == 0) ? int'($urandom_range(1024, 2047)) : int'($urandom_range(0, 1023));
   endfunction

   function automatic int rnd_py();
      return ($urandom_range(0, 9) == 0) ? int'($urandom_range(768, 1023)) : int'($urandom_range(0, 767));
   endfunction

   initial begin
      reset_n = 1'b0; obj_we = 1'b0; obj_idx = '0; obj_px = '0; obj_py = '0; obj_valid = 1'b0;
      frame_clear = 1'b0; hcount = '0; vcount = '0; hsync = 1'b1; vsync = 1'b1; blank = 1'b0;
      in_pixel = 24'h00FF00;
      for (int i = 0; i < NUM_OBJ; i++) begin
         sh_v[i] = 0; sh_x[i] = 0; sh_y[i] = 0; ac_v[i] = 0; ac_x[i] = 0; ac_y[i] = 0;
      end

      repeat (3) tick();
      check_eq("rst_pixel", out_pixel, 24'h000000);
      check_eq("rst_count", obj_count, 0);
      check_eq("rst_hsync", out_hsync, 1'b1);
      check_eq("rst_vsync", out_vsync, 1'b1);
      reset_n = 1'b1;
      tick();
      tick();
      check_eq("release_pixel", out_pixel, 24'h00FF00);

      // Basic marker
      in_pixel = 24'h123456;
      wr(0, 100, 200, 1'b1);
      vpulse_wr(1'b0, 0, 0, 0);
      check_eq("basic_count", obj_count, 1);
      hcount = 11'd100; vcount = 10'd200;
      repeat (3) tick();
      check_eq("basic_center", out_pixel, MARK_COLOR);
      hcount = 11'd95;
      repeat (3) tick();
      check_eq("basic_left_out", out_pixel, 24'h123456);
      scan_win(100, 200);

      // Double buffering: mid-frame write, then a write in the exact swap cycle
      wr(1, 300, 300, 1'b1);
      scan_win(300, 300);
      vpulse_wr(1'b1, 5, 600, 500);
      scan_win(300, 300);
      scan_win(600, 500);
      vpulse_wr(1'b0, 0, 0, 0);
      scan_win(600, 500);

      // Boundaries
      wr(2, 2, 0, 1'b1);
      wr(3, 500, 1020, 1'b1);
      wr(4, 1500, 400, 1'b1);
      wr(7, 700, 700, 1'b1);
      vpulse_wr(1'b0, 0, 0, 0);
      scan_win(2, 0);
      scan_win(500, 1020);
      scan_win(500, 0);
      scan_win(1500, 400);
      scan_win(700, 700);

      // Clear/write collision
      wr(0, 50, 50, 1'b1);
      wr(1, 150, 50, 1'b1);
      wr(2, 250, 50, 1'b1);
      wr(3, 350, 50, 1'b1);
      frame_clear = 1'b1;
      set_write(2, 250, 60, 1'b1);
      tick();
      vpulse_wr(1'b0, 0, 0, 0);
      check_eq("collide_count", obj_count, 1);
      scan_win(50, 50);
      scan_win(250, 60);

      // Blank over a marker, then mid-frame reset
      force_blank = 1'b1;
      scan_win(250, 60);
      force_blank = 1'b0;
      reset_n = 1'b0;
      tick();
      reset_n = 1'b1;
      scan_win(250, 60);
      vpulse_wr(1'b0, 0, 0, 0);
      check_eq("reset_count", obj_count, 0);
      scan_win(250, 60);

      // Randomized traffic
      rnd_mode = 1'b1;
      for (int it = 0; it < 80; it++) begin
         int op = int'($urandom_range(0, 9));
         if (op < 4) begin
            wr(int'($urandom_range(0, 7)), rnd_px(), rnd_py(), $urandom_range(0, 3) != 0);
         end else if (op == 4) begin
            frame_clear = 1'b1;
            if ($urandom_range(0, 1) == 1) set_write(int'($urandom_range(0, 7)), rnd_px(), rnd_py(), 1'b1);
            tick();
         end else if (op == 5) begin
            vpulse_wr($urandom_range(0, 1) == 1, int'($urandom_range(0, 7)), rnd_px(), rnd_py());
         end else if (op < 9) begin
            int k = int'($urandom_range(0, NUM_OBJ - 1));
            scan_win(ac_x[k] > 2047 ? 0 : ac_x[k], ac_y[k] > 1023 ? 0 : ac_y[k]);
         end else begin
            for (int j = 0; j < 20; j++) pix_at(int'($urandom_range(0, 1100)), int'($urandom_range(0, 800)));
         end
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
